// File: rtl/pipe_hazard_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_tracker_if
// Description : D-stage request / hazard-response bundle for pipe_hazard_tracker.
//               stall_cnt exists only when PIPE_STALL_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_tracker_if #(
  parameter int FSEL_W = 2
) ();
  logic [31:0]       D_instr;
  logic              D_valid;
  logic              flush;
  logic              stall;
  logic [FSEL_W-1:0] fwd_sel_rs;
  logic [FSEL_W-1:0] fwd_sel_rt;
  logic              W_we;
  logic [4:0]        W_waddr;
  logic [1:0]        W_wdsel;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  modport master (
    output D_instr, D_valid, flush,
`ifdef PIPE_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  stall, fwd_sel_rs, fwd_sel_rt, W_we, W_waddr, W_wdsel
  );

  modport slave (
    input  D_instr, D_valid, flush,
`ifdef PIPE_STALL_CNT_EN
    output stall_cnt,
`endif
    output stall, fwd_sel_rs, fwd_sel_rt, W_we, W_waddr, W_wdsel
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_tracker
// Description : Decodes the D-stage instruction once, carries dest/Tnew down
//               NUM_STAGES stages, and produces stall, forward selects and
//               write-back controls. Optional macro: PIPE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_tracker #(
  parameter int NUM_STAGES = 3,
  parameter int TNEW_W     = 2,
  parameter int FSEL_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_hazard_tracker_if.slave  bus
);
  localparam int         c_last      = NUM_STAGES - 1;
  localparam logic [5:0] c_op_rtype  = 6'b000000;
  localparam logic [5:0] c_op_ori    = 6'b001101;
  localparam logic [5:0] c_op_lui    = 6'b001111;
  localparam logic [5:0] c_op_lw     = 6'b100011;
  localparam logic [5:0] c_op_sw     = 6'b101011;
  localparam logic [5:0] c_op_beq    = 6'b000100;
  localparam logic [5:0] c_op_jal    = 6'b000011;
  localparam logic [5:0] c_fn_add    = 6'b100000;
  localparam logic [5:0] c_fn_sub    = 6'b100010;
  localparam logic [5:0] c_fn_jr     = 6'b001000;

  logic              r_valid [NUM_STAGES];
  logic              r_we    [NUM_STAGES];
  logic [4:0]        r_dst   [NUM_STAGES];
  logic [TNEW_W-1:0] r_tnew  [NUM_STAGES];
  logic [1:0]        r_wdsel [NUM_STAGES];

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd;
  logic              w_has_dst, w_use_rs, w_use_rt, w_load, w_stall;
  logic [4:0]        w_dst;
  logic [TNEW_W-1:0] w_tnew, w_tuse_rs, w_tuse_rt;
  logic [1:0]        w_wdsel;
  logic              w_rs_hit, w_rt_hit;
  logic [TNEW_W-1:0] w_rs_tnew, w_rt_tnew;
  logic [FSEL_W-1:0] w_rs_sel, w_rt_sel;
  logic              w_unused;

  assign w_op     = bus.D_instr[31:26];
  assign w_rs     = bus.D_instr[25:21];
  assign w_rt     = bus.D_instr[20:16];
  assign w_rd     = bus.D_instr[15:11];
  assign w_funct  = bus.D_instr[5:0];
  assign w_unused = ^bus.D_instr[10:6];

  always_comb begin
    w_has_dst = 1'b0;
    w_dst     = 5'd0;
    w_tnew    = '0;
    w_wdsel   = 2'b00;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_tuse_rs = '0;
    w_tuse_rt = '0;
    case (w_op)
      c_op_rtype: begin
        if (w_funct == c_fn_add || w_funct == c_fn_sub) begin
          w_has_dst = 1'b1;
          w_dst     = w_rd;
          w_tnew    = TNEW_W'(1);
          w_use_rs  = 1'b1;
          w_use_rt  = 1'b1;
        end else if (w_funct == c_fn_jr) begin
          w_use_rs  = 1'b1;
        end
      end
      c_op_ori: begin
        w_has_dst = 1'b1;
        w_dst     = w_rt;
        w_tnew    = TNEW_W'(1);
        w_use_rs  = 1'b1;
      end
      c_op_lui: begin
        w_has_dst = 1'b1;
        w_dst     = w_rt;
        w_tnew    = TNEW_W'(1);
      end
      c_op_lw: begin
        w_has_dst = 1'b1;
        w_dst     = w_rt;
        w_tnew    = TNEW_W'(2);
        w_wdsel   = 2'b01;
        w_use_rs  = 1'b1;
      end
      c_op_sw: begin
        w_use_rs  = 1'b1;
        w_use_rt  = 1'b1;
        w_tuse_rt = TNEW_W'(1);
      end
      c_op_beq: begin
        w_use_rs  = 1'b1;
        w_use_rt  = 1'b1;
      end
      c_op_jal: begin
        w_has_dst = 1'b1;
        w_dst     = 5'd31;
        w_wdsel   = 2'b10;
      end
      default: ;
    endcase
  end

  // Scan oldest to youngest so the youngest (lowest index) match wins.
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rt_hit  = 1'b0;
    w_rs_tnew = '0;
    w_rt_tnew = '0;
    w_rs_sel  = '0;
    w_rt_sel  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (r_we[i] && r_dst[i] == w_rs && w_rs != 5'd0) begin
        w_rs_hit  = 1'b1;
        w_rs_tnew = r_tnew[i];
        w_rs_sel  = FSEL_W'(i + 1);
      end
      if (r_we[i] && r_dst[i] == w_rt && w_rt != 5'd0) begin
        w_rt_hit  = 1'b1;
        w_rt_tnew = r_tnew[i];
        w_rt_sel  = FSEL_W'(i + 1);
      end
    end
  end

  // A bubble in D reads nothing, so it can never stall.
  assign w_stall = bus.D_valid &&
                   ((w_use_rs && w_rs_hit && (w_rs_tnew > w_tuse_rs)) ||
                    (w_use_rt && w_rt_hit && (w_rt_tnew > w_tuse_rt)));
  assign w_load  = bus.D_valid && !w_stall && !bus.flush;

  assign bus.stall      = w_stall;
  assign bus.fwd_sel_rs = (w_rs_hit && w_rs_tnew == '0) ? w_rs_sel : '0;
  assign bus.fwd_sel_rt = (w_rt_hit && w_rt_tnew == '0) ? w_rt_sel : '0;
  assign bus.W_we       = r_valid[c_last] && r_we[c_last];
  assign bus.W_waddr    = r_valid[c_last] ? r_dst[c_last] : 5'd0;
  assign bus.W_wdsel    = r_valid[c_last] ? r_wdsel[c_last] : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_valid[i] <= 1'b0;
        r_we[i]    <= 1'b0;
        r_dst[i]   <= 5'd0;
        r_tnew[i]  <= '0;
        r_wdsel[i] <= 2'b00;
      end
    end else begin
      r_valid[0] <= w_load;
      r_we[0]    <= w_load && w_has_dst && (w_dst != 5'd0);
      r_dst[0]   <= w_load ? w_dst : 5'd0;
      r_tnew[0]  <= w_load ? w_tnew : '0;
      r_wdsel[0] <= w_load ? w_wdsel : 2'b00;
      for (int i = 1; i < NUM_STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_we[i]    <= r_we[i-1];
        r_dst[i]   <= r_dst[i-1];
        r_tnew[i]  <= (r_tnew[i-1] != '0) ? r_tnew[i-1] - TNEW_W'(1) : '0;
        r_wdsel[i] <= r_wdsel[i-1];
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
